// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared sizing helpers and drain FSM encoding for the systolic
//               array and its writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Accumulator width: full product, growth for K-deep summation, one guard bit.
    function automatic int outcome_width(input int dw, input int k);
        return 2 * dw + ((k == 1) ? 0 : $clog2(k)) + 1;
    endfunction

    // Result elements that fit in one output SRAM word (IPW).
    function automatic int items_per_word(input int sram_dw, input int dw);
        return sram_dw / dw;
    endfunction

    // Output words needed to hold one full result row (ROW_WORDS).
    function automatic int row_words(input int array_size, input int ipw);
        return (array_size + ipw - 1) / ipw;
    endfunction

    // Drain sequencer states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_writeback_if
// Description : Valid/ready write port between the writeback stage and the
//               output SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_writeback_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int SRAM_DATA_WIDTH = 32
);
    logic                       sram_wen;
    logic                       sram_wready;
    logic [ADDR_WIDTH-1:0]      sram_waddr;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata;

    modport master (
        output sram_wen,
        output sram_waddr,
        output sram_wdata,
        input  sram_wready
    );

    modport slave (
        input  sram_wen,
        input  sram_waddr,
        input  sram_wdata,
        output sram_wready
    );
endinterface
`default_nettype wire

// File: rtl/systolic_writeback_requant_sat.sv
`default_nettype none
// ============================================================================
// Module      : requant_sat
// Description : Rounding arithmetic right shift of one accumulator followed by
//               saturation to a signed DATA_WIDTH result. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_sat #(
    parameter int DATA_WIDTH    = 8,
    parameter int OUTCOME_WIDTH = 20
) (
    input  wire logic signed [OUTCOME_WIDTH-1:0] acc,
    input  wire logic        [4:0]               shift_amt,
    output logic      signed [DATA_WIDTH-1:0]    q
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int                      c_EW   = OUTCOME_WIDTH + 1;
    localparam logic [5:0]              c_OW_S = 6'(OUTCOME_WIDTH);
    localparam logic signed [c_EW-1:0]  c_MAX  = c_EW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_EW-1:0]  c_MIN  = c_EW'(-(2 ** (DATA_WIDTH - 1)));

    logic signed [c_EW-1:0] w_ext;
    logic signed [c_EW-1:0] w_rnd;
    logic signed [c_EW-1:0] w_sum;
    logic signed [c_EW-1:0] w_shr;

    // Round half up, shift, then clamp; oversized shifts collapse to the sign.
    always_comb begin
        w_ext = {acc[OUTCOME_WIDTH-1], acc};
        w_rnd = '0;
        if (shift_amt != 5'd0) begin
            w_rnd = c_EW'(1) << (shift_amt - 5'd1);
        end
        w_sum = w_ext + w_rnd;
        w_shr = w_sum >>> shift_amt;
        if ({1'b0, shift_amt} >= c_OW_S) begin
            q = acc[OUTCOME_WIDTH-1] ? '1 : '0;
        end else if (w_shr > c_MAX) begin
            q = c_MAX[DATA_WIDTH-1:0];
        end else if (w_shr < c_MIN) begin
            q = c_MIN[DATA_WIDTH-1:0];
        end else begin
            q = w_shr[DATA_WIDTH-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/systolic_writeback.sv
`default_nettype none
// ============================================================================
// Module      : systolic_writeback
// Description : Drains the systolic array row by row, requantizes each column
//               to DATA_WIDTH, packs MSB-first into SRAM words and writes them
//               through a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_writeback
    import systolic_pkg::*;
#(
    parameter  int ARRAY_SIZE      = 8,
    parameter  int DATA_WIDTH      = 8,
    parameter  int K_ACCUM_DEPTH   = 8,
    parameter  int SRAM_DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH      = 10,
    localparam int OUTCOME_WIDTH   = outcome_width(DATA_WIDTH, K_ACCUM_DEPTH)
) (
    input  wire logic                                clk,
    input  wire logic                                srst,
    input  wire logic                                start,
    input  wire logic [ADDR_WIDTH-1:0]               base_addr,
    input  wire logic [4:0]                          shift_amt,
    input  wire logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic      [5:0]                          matrix_index,
    output logic                                     busy,
    output logic                                     done,
    systolic_writeback_if.master                     sram
);
    localparam int         c_IPW       = items_per_word(SRAM_DATA_WIDTH, DATA_WIDTH);
    localparam int         c_ROW_WORDS = row_words(ARRAY_SIZE, c_IPW);
    localparam int         c_WORD_W    = (c_ROW_WORDS > 1) ? $clog2(c_ROW_WORDS) : 1;
    localparam logic [5:0] c_LAST_ROW  = 6'(ARRAY_SIZE - 1);

    wb_state_t                  r_state;
    wb_state_t                  w_next;
    logic [5:0]                 r_row;
    logic [c_WORD_W-1:0]        r_word;
    logic [ADDR_WIDTH-1:0]      r_base;
    logic [4:0]                 r_shift;
    logic [SRAM_DATA_WIDTH-1:0] r_buf  [c_ROW_WORDS];
    logic [SRAM_DATA_WIDTH-1:0] w_pack [c_ROW_WORDS];
    logic signed [DATA_WIDTH-1:0] w_q  [ARRAY_SIZE];
    logic                       w_last_word;
    logic                       w_last_row;
    logic [ADDR_WIDTH-1:0]      w_off;

    assign w_last_word = (r_word == c_WORD_W'(c_ROW_WORDS - 1));
    assign w_last_row  = (r_row == c_LAST_ROW);
    assign w_off       = ADDR_WIDTH'(int'(r_row) * c_ROW_WORDS + int'(r_word));

    // The row counter doubles as the array row select; it only moves at row
    // boundaries, so it naturally holds its last value outside CAPTURE.
    assign matrix_index = r_row;

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
        requant_sat #(
            .DATA_WIDTH    (DATA_WIDTH),
            .OUTCOME_WIDTH (OUTCOME_WIDTH)
        ) u_requant (
            .acc       (mul_outcome[j*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
            .shift_amt (r_shift),
            .q         (w_q[j])
        );
    end

    // Pack requantized columns MSB-first; unused tail lanes stay zero.
    always_comb begin
        for (int w = 0; w < c_ROW_WORDS; w++) begin
            w_pack[w] = '0;
        end
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            w_pack[j / c_IPW][SRAM_DATA_WIDTH - 1 - DATA_WIDTH * (j % c_IPW) -: DATA_WIDTH] = w_q[j];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: advance rows after the last word of each row is accepted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_WRITE;
            S_WRITE: begin
                if (sram.sram_wready && w_last_word) begin
                    w_next = w_last_row ? S_DONE : S_CAPTURE;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Job parameters, row/word counters and the captured row buffer.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_row   <= '0;
            r_word  <= '0;
            r_base  <= '0;
            r_shift <= '0;
            for (int w = 0; w < c_ROW_WORDS; w++) begin
                r_buf[w] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_shift <= shift_amt;
                        r_row   <= '0;
                        r_word  <= '0;
                    end
                end
                S_CAPTURE: begin
                    for (int w = 0; w < c_ROW_WORDS; w++) begin
                        r_buf[w] <= w_pack[w];
                    end
                end
                S_WRITE: begin
                    if (sram.sram_wready) begin
                        if (w_last_word) begin
                            r_word <= '0;
                            if (!w_last_row) begin
                                r_row <= r_row + 6'd1;
                            end
                        end else begin
                            r_word <= r_word + c_WORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; address and data are stable through stalls.
    always_comb begin
        sram.sram_wen   = 1'b0;
        sram.sram_waddr = '0;
        sram.sram_wdata = '0;
        busy            = (r_state != S_IDLE);
        done            = (r_state == S_DONE);
        if (r_state == S_WRITE) begin
            sram.sram_wen   = 1'b1;
            sram.sram_waddr = r_base + w_off;
            sram.sram_wdata = r_buf[r_word];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_writeback
// Description : Self-checking bench for systolic_writeback: requant vector
//               table, fixed pattern, randomized rows against a reference
//               model, stall, mid-job reset and address wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_writeback;
    import systolic_pkg::*;

    localparam int AS   = 8;
    localparam int DW   = 8;
    localparam int KD   = 8;
    localparam int SDW  = 32;
    localparam int AW   = 10;
    localparam int OW   = outcome_width(DW, KD);
    localparam int IPWL = SDW / DW;
    localparam int RW   = (AS + IPWL - 1) / IPWL;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [SDW-1:0] data;
    } wr_t;

    typedef struct {
        int         x;
        int         s;
        logic [7:0] q;
    } rq_vec_t;

    logic              clk = 1'b0;
    logic              srst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [4:0]        shift_amt;
    logic [AS*OW-1:0]  mul_outcome;
    logic [5:0]        matrix_index;
    logic              busy;
    logic              done;
    logic              wready;

    int  acc [AS][AS];
    wr_t exp_q [$];
    int  n_tests = 0;
    int  n_fail  = 0;

    systolic_writeback_if #(.ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(SDW)) sram ();
    assign sram.sram_wready = wready;

    systolic_writeback #(
        .ARRAY_SIZE      (AS),
        .DATA_WIDTH      (DW),
        .K_ACCUM_DEPTH   (KD),
        .SRAM_DATA_WIDTH (SDW),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .start        (start),
        .base_addr    (base_addr),
        .shift_amt    (shift_amt),
        .mul_outcome  (mul_outcome),
        .matrix_index (matrix_index),
        .busy         (busy),
        .done         (done),
        .sram         (sram)
    );

    always #5 clk = ~clk;

    // Array model: the selected row appears combinationally.
    always_comb begin
        mul_outcome = '0;
        if (int'(matrix_index) < AS) begin
            for (int j = 0; j < AS; j++) begin
                mul_outcome[j*OW +: OW] = OW'(acc[int'(matrix_index)][j]);
            end
        end
    end

    // Reference requantization from the arithmetic rule.
    function automatic int ref_q(input int x, input int s);
        longint v;
        if (s >= OW) return (x < 0) ? -1 : 0;
        v = longint'(x) + ((s > 0) ? (longint'(1) << (s - 1)) : longint'(0));
        v = v >>> s;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    function automatic logic [SDW-1:0] ref_word(input int r, input int w, input int s);
        logic [SDW-1:0] v;
        int j;
        v = '0;
        for (int k = 0; k < IPWL; k++) begin
            j = w * IPWL + k;
            v = v << DW;
            if (j < AS) v[DW-1:0] = DW'(ref_q(acc[r][j], s));
        end
        return v;
    endfunction

    task automatic push_model(input int b, input int s);
        wr_t e;
        for (int r = 0; r < AS; r++) begin
            for (int w = 0; w < RW; w++) begin
                e.addr = AW'(b + r * RW + w);
                e.data = ref_word(r, w, s);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < AS; r++) begin
            for (int j = 0; j < AS; j++) begin
                if ($urandom_range(0, 3) == 0) acc[r][j] = int'($urandom_range(0, 64)) - 32;
                else                           acc[r][j] = int'($urandom_range(0, 1048575)) - 524288;
            end
        end
    endtask

    // Runs one drain job starting at the current falling edge.
    task automatic run_job(input logic [AW-1:0] b, input logic [4:0] s, input int stall_addr,
                           input int stall_len, input int rst_at, input int exp_done,
                           input bit pulse_busy, input bit start_in_done);
        int  cyc;
        int  stalls;
        bit  fin;
        wr_t head;
        base_addr = b;
        shift_amt = s;
        start     = 1'b1;
        cyc       = 0;
        stalls    = stall_len;
        fin       = 1'b0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start     = (pulse_busy && (cyc == 3 || cyc == 10 || cyc == 20)) ? 1'b1 : 1'b0;
            base_addr = AW'($urandom);
            shift_amt = 5'($urandom);
            wready    = 1'b1;
            if (sram.sram_wen) begin
                if (exp_q.size() == 0) begin
                    check("extra_write", 64'(sram.sram_waddr), 64'hFFFF);
                end else begin
                    head = exp_q[0];
                    if (stall_addr >= 0 && int'(sram.sram_waddr) == stall_addr && stalls > 0) begin
                        wready = 1'b0;
                        stalls--;
                        check("stall_addr_hold", 64'(sram.sram_waddr), 64'(head.addr));
                        check("stall_data_hold", 64'(sram.sram_wdata), 64'(head.data));
                    end else begin
                        head = exp_q.pop_front();
                        check("wr_addr", 64'(sram.sram_waddr), 64'(head.addr));
                        check("wr_data", 64'(sram.sram_wdata), 64'(head.data));
                    end
                end
            end
            if (done) begin
                check("done_cycle", 64'(cyc), 64'(exp_done));
                check("writes_left", 64'(exp_q.size()), 64'd0);
                fin   = 1'b1;
                start = start_in_done;
            end
            if (rst_at == cyc) begin
                srst = 1'b1;
                fin  = 1'b1;
            end
        end
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL job_timeout: got no done after %0d cycles, required cycle %0d", cyc, exp_done);
        end
        @(negedge clk);
        start = 1'b0;
        if (rst_at >= 0) begin
            srst = 1'b0;
            check("rst_wen",   64'(sram.sram_wen), 64'd0);
            check("rst_busy",  64'(busy), 64'd0);
            check("rst_done",  64'(done), 64'd0);
            check("rst_index", 64'(matrix_index), 64'd0);
            check("rst_waddr", 64'(sram.sram_waddr), 64'd0);
            check("rst_wdata", 64'(sram.sram_wdata), 64'd0);
            repeat (3) begin
                @(negedge clk);
                check("post_rst_no_wen", 64'(sram.sram_wen), 64'd0);
            end
        end else begin
            check("done_one_cycle", 64'(done), 64'd0);
            check("idle_after_done", 64'(busy), 64'd0);
        end
    endtask

    rq_vec_t tbl [13];
    wr_t     e;

    initial begin
        tbl = '{
            '{100,      0,  8'h64}, '{200000,  2, 8'h7F}, '{-200000, 2, 8'h80},
            '{6,        2,  8'h02}, '{-6,      2, 8'hFF}, '{7,       1, 8'h04},
            '{-7,       1,  8'hFD}, '{511,     2, 8'h7F}, '{509,     2, 8'h7F},
            '{-513,     2,  8'h80}, '{-5,     20, 8'hFF}, '{5,      31, 8'h00},
            '{-524288, 19,  8'hFF}
        };

        srst      = 1'b1;
        start     = 1'b0;
        wready    = 1'b1;
        base_addr = '0;
        shift_amt = '0;
        for (int r = 0; r < AS; r++) for (int j = 0; j < AS; j++) acc[r][j] = 0;
        repeat (3) @(negedge clk);
        check("reset_index", 64'(matrix_index), 64'd0);
        check("reset_wen",   64'(sram.sram_wen), 64'd0);
        check("reset_waddr", 64'(sram.sram_waddr), 64'd0);
        check("reset_wdata", 64'(sram.sram_wdata), 64'd0);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_done",  64'(done), 64'd0);
        srst = 1'b0;
        @(negedge clk);

        // Requantization vector table: every lane of every word carries q.
        for (int i = 0; i < 13; i++) begin
            for (int r = 0; r < AS; r++) for (int j = 0; j < AS; j++) acc[r][j] = tbl[i].x;
            for (int k = 0; k < AS * RW; k++) begin
                e.addr = AW'(i * 16 + k);
                e.data = {4{tbl[i].q}};
                exp_q.push_back(e);
            end
            run_job(AW'(i * 16), 5'(tbl[i].s), -1, 0, -1, 25, 1'b0, 1'b0);
        end

        // Column ramp 256*j-1000 with shift 4.
        for (int r = 0; r < AS; r++) for (int j = 0; j < AS; j++) acc[r][j] = 256 * j - 1000;
        for (int r = 0; r < AS; r++) begin
            e.addr = AW'(10'h200 + 2 * r);     e.data = 32'hC2D2E2F2; exp_q.push_back(e);
            e.addr = AW'(10'h200 + 2 * r + 1); e.data = 32'h02122232; exp_q.push_back(e);
        end
        run_job(10'h200, 5'd4, -1, 0, -1, 25, 1'b0, 1'b0);

        // Randomized rows and shifts against the reference model.
        for (int t = 0; t < 4; t++) begin
            int b;
            int s;
            b = int'($urandom_range(0, 1023));
            s = int'($urandom_range(0, 23));
            fill_random();
            push_model(b, s);
            run_job(AW'(b), 5'(s), -1, 0, -1, 25, 1'b0, 1'b0);
        end

        // Three stall cycles on row 2 word 1.
        fill_random();
        push_model(10'h100, 3);
        run_job(10'h100, 5'd3, 10'h100 + 5, 3, -1, 28, 1'b0, 1'b0);

        // Reset during row 4 WRITE, then a clean job.
        fill_random();
        push_model(10'h040, 5);
        run_job(10'h040, 5'd5, -1, 0, 14, 25, 1'b0, 1'b0);
        check("rst_writes_remaining", 64'(exp_q.size()), 64'd7);
        exp_q.delete();
        fill_random();
        push_model(10'h000, 6);
        run_job(10'h000, 5'd6, -1, 0, -1, 25, 1'b0, 1'b0);

        // Address wrap with ignored starts while busy and in the DONE cycle.
        fill_random();
        push_model(10'h3F8, 7);
        run_job(10'h3F8, 5'd7, -1, 0, -1, 25, 1'b1, 1'b1);
        fill_random();
        push_model(10'h3FC, 2);
        run_job(10'h3FC, 5'd2, -1, 0, -1, 25, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
